// File: rtl/desroteamento.sv
// -----------------------------------------------------------------------------
// desroteamento: 1-to-4 distributor with a valid/ready input handshake.
//
// One input word is steered into one of four registered output slots
// (A, B, C, D). Each slot holds its word with a valid flag until the slot's
// consumer acknowledges it. A full destination slot back-pressures the
// producer through in_ready. A slot that is being acknowledged in the current
// cycle may be refilled in that same cycle.
//
// Build option:
//   DESROTEAMENTO_ROUND_ROBIN_EN - when defined, SEL is ignored and the
//   destination comes from an internal 2-bit pointer. The pointer advances
//   (mod 4) on each accepted word only and waits on a full slot without
//   skipping it. When undefined, the destination is SEL and no pointer
//   logic exists. The port list is the same in both builds.
// -----------------------------------------------------------------------------
module desroteamento #(
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] Entrada,
  input  logic [1:0]        SEL,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N_BITS-1:0] Saida_A,
  output logic [N_BITS-1:0] Saida_B,
  output logic [N_BITS-1:0] Saida_C,
  output logic [N_BITS-1:0] Saida_D,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ack
);

  localparam int N_SLOTS = 4;

  // Slot storage: one word and one full flag per destination.
  logic [N_BITS-1:0] slot_data_q [N_SLOTS];
  logic [N_BITS-1:0] slot_data_d [N_SLOTS];
  logic [3:0]        slot_valid_q;
  logic [3:0]        slot_valid_d;

  // Destination index for the word currently presented.
  logic [1:0] target;

  // A word is taken when the producer offers it and the target can take it.
  // Accepts are ignored while reset is asserted.
  logic accept;

`ifdef DESROTEAMENTO_ROUND_ROBIN_EN
  // Round-robin destination pointer; SEL plays no part in this build.
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic       sel_unused;

  assign sel_unused = ^SEL;
  assign target     = ptr_q;

  // Advance the pointer only on an accepted word, wrapping 3 -> 0.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  // Pointer register with synchronous reset back to slot A.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Destination comes straight from the select input.
  assign target = SEL;
`endif

  // Ready depends only on the target slot's state and its ack, never on
  // in_valid, so the producer may look at it before committing a word.
  assign in_ready = !slot_valid_q[target] || out_ack[target];
  assign accept   = in_valid && in_ready && !reset;

  // Next-state for every slot: load on accept, clear flag on ack, else hold.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    slot_valid_d = slot_valid_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_data_d[i] = slot_data_q[i];
    end

    for (int i = 0; i < N_SLOTS; i++) begin
      if (accept && (target == 2'(i))) begin
        // Load wins over a simultaneous ack: the slot stays full with the
        // new word.
        slot_data_d[i]  = Entrada;
        slot_valid_d[i] = 1'b1;
      end else if (slot_valid_q[i] && out_ack[i]) begin
        // Consumer took the word; data is left in place, only the flag drops.
        slot_valid_d[i] = 1'b0;
      end
    end
  end

  // Slot registers with synchronous reset; a word held at reset is discarded.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled before the edge.
    if (reset) begin
      // NOTE: the slot data registers are reset as well as the flags because
      // the outputs must read zero after reset, not just be marked empty.
      slot_valid_q <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_data_q[i] <= '0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_data_q[i] <= slot_data_d[i];
      end
    end
  end

  // Registered outputs map directly onto the slot storage.
  assign Saida_A   = slot_data_q[0];
  assign Saida_B   = slot_data_q[1];
  assign Saida_C   = slot_data_q[2];
  assign Saida_D   = slot_data_q[3];
  assign out_valid = slot_valid_q;

endmodule

// File: tb/tb_desroteamento.sv
// -----------------------------------------------------------------------------
// tb_desroteamento: self-checking bench for desroteamento (default build,
// destination taken from SEL). A behavioural model of the four slots tracks
// the expected contents; directed steps cover reset, routing, back-pressure,
// same-cycle refill, acks and reset mid-operation, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_desroteamento;

  localparam int N_BITS = 4;

  logic              clk;
  logic              reset;
  logic [N_BITS-1:0] Entrada;
  logic [1:0]        SEL;
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] Saida_A;
  logic [N_BITS-1:0] Saida_B;
  logic [N_BITS-1:0] Saida_C;
  logic [N_BITS-1:0] Saida_D;
  logic [3:0]        out_valid;
  logic [3:0]        out_ack;

  desroteamento #(.N_BITS(N_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .Entrada   (Entrada),
    .SEL       (SEL),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Saida_A   (Saida_A),
    .Saida_B   (Saida_B),
    .Saida_C   (Saida_C),
    .Saida_D   (Saida_D),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what each slot should hold and whether it is full.
  logic [N_BITS-1:0] m_data  [4];
  bit                m_full  [4];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_BITS-1:0] dut_slot(input int i);
    case (i)
      0:       return Saida_A;
      1:       return Saida_B;
      2:       return Saida_C;
      default: return Saida_D;
    endcase
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_full[i];
    return v;
  endfunction

  // One clock of stimulus: drive at the falling edge, check the combinational
  // ready, advance the model at the rising edge, then check registered state.
  task automatic cycle(input logic rst, input logic [N_BITS-1:0] data,
                       input logic [1:0] sel, input logic vld,
                       input logic [3:0] ack, input string tag);
    bit exp_ready;
    bit take;
    @(negedge clk);
    reset    = rst;
    Entrada  = data;
    SEL      = sel;
    in_valid = vld;
    out_ack  = ack;
    #1;
    exp_ready = !m_full[sel] || ack[sel];
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    take = vld && exp_ready && !rst;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_data[i] = '0;
        m_full[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (take && sel == 2'(i)) begin
          m_data[i] = data;
          m_full[i] = 1'b1;
        end else if (ack[i]) begin
          m_full[i] = 1'b0;
        end
      end
    end
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(model_valid()));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s.Saida%0d", tag, i), 32'(dut_slot(i)),
            32'(m_data[i]));
    end
  endtask

  initial begin
    reset    = 1'b1;
    Entrada  = '0;
    SEL      = 2'b00;
    in_valid = 1'b0;
    out_ack  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = '0;
      m_full[i] = 1'b0;
    end

    // Reset for two cycles, then ready must be high for every destination.
    cycle(1'b1, 4'h0, 2'b00, 1'b0, 4'b0000, "rst0");
    cycle(1'b1, 4'h0, 2'b00, 1'b0, 4'b0000, "rst1");
    for (int s = 0; s < 4; s++) begin
      cycle(1'b0, 4'h0, 2'(s), 1'b0, 4'b0000, $sformatf("idle%0d", s));
    end
    check("reset.valid_lit", 32'(out_valid), 32'h0);

    // Route one word to each slot on consecutive cycles, no acks.
    cycle(1'b0, 4'h3, 2'b00, 1'b1, 4'b0000, "routeA");
    check("routeA.lat", 32'(Saida_A), 32'h3);
    cycle(1'b0, 4'h5, 2'b01, 1'b1, 4'b0000, "routeB");
    cycle(1'b0, 4'hA, 2'b10, 1'b1, 4'b0000, "routeC");
    cycle(1'b0, 4'hF, 2'b11, 1'b1, 4'b0000, "routeD");
    check("route.valid_lit", 32'(out_valid), 32'hF);
    check("route.D_lit", 32'(Saida_D), 32'hF);

    // Back-pressure on full slot B: nothing may change.
    cycle(1'b0, 4'h7, 2'b01, 1'b1, 4'b0000, "bp");
    check("bp.B_lit", 32'(Saida_B), 32'h5);

    // Ack and refill slot B in the same cycle.
    cycle(1'b0, 4'h9, 2'b01, 1'b1, 4'b0010, "refill");
    check("refill.B_lit", 32'(Saida_B), 32'h9);
    check("refill.vB_lit", 32'(out_valid[1]), 32'h1);

    // Acks on A and C clear flags but leave data in place.
    cycle(1'b0, 4'h1, 2'b00, 1'b0, 4'b0101, "ackAC");
    check("ackAC.valid_lit", 32'(out_valid), 32'hA);
    check("ackAC.A_lit", 32'(Saida_A), 32'h3);
    // Ack on an already-empty slot has no effect.
    cycle(1'b0, 4'h1, 2'b00, 1'b0, 4'b0001, "ackEmpty");

    // Refill everything, then reset with a word on offer.
    cycle(1'b0, 4'h4, 2'b00, 1'b1, 4'b0000, "fillA");
    cycle(1'b0, 4'h6, 2'b10, 1'b1, 4'b0000, "fillC");
    check("fill.valid_lit", 32'(out_valid), 32'hF);
    cycle(1'b1, 4'hE, 2'b00, 1'b1, 4'b0000, "rstMid");
    check("rstMid.A_lit", 32'(Saida_A), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            N_BITS'($urandom), 2'($urandom), 1'($urandom),
            4'($urandom & $urandom), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/desroteamento.md
Name: desroteamento

Overview:
- 1-to-4 distributor: the write-side counterpart of the 4:1 selection block (Roteamento).
- A single input word is steered by SEL into one of four registered output slots (A, B, C, D).
- Each slot holds one word with a valid flag until its consumer acknowledges it.
- The input side has a valid/ready handshake, so a full target slot back-pressures the producer.

Parameters:
- N_BITS, 4, width of the data word and of each output slot.

Ports:
- clk  input  1  system clock; rising edge only
- reset  input  1  synchronous reset, active-high
- Entrada  input  N_BITS  input data word
- SEL  input  2  destination select: 00=A, 01=B, 10=C, 11=D
- in_valid  input  1  producer presents Entrada/SEL this cycle
- in_ready  output  1  block can accept a word this cycle (combinational)
- Saida_A  output  N_BITS  slot A data (registered)
- Saida_B  output  N_BITS  slot B data (registered)
- Saida_C  output  N_BITS  slot C data (registered)
- Saida_D  output  N_BITS  slot D data (registered)
- out_valid  output  4  per-slot full flag; bit0=A .. bit3=D (registered)
- out_ack  input  4  per-slot consumer acknowledge; bit0=A .. bit3=D

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port reset.
- Reset (sampled at clk edge):
  - Saida_A..Saida_D = 0, out_valid = 4'b0000.
  - Any word held mid-operation is discarded.
  - in_ready during reset follows the formula below; accepts are ignored while reset=1.
- Let t = destination index, i.e. SEL (or the pointer when the macro is on).
- in_ready = !out_valid[t] || out_ack[t].
  - Purely combinational, no dependency on in_valid.
  - A slot being acked this cycle may be refilled in the same cycle.
- Accept when in_valid && in_ready at the rising edge:
  - Saida_t <= Entrada; out_valid[t] <= 1.
  - Latency: word visible on Saida_t exactly 1 cycle after acceptance.
- Per slot i, at each edge:
  - Accept targeting i: load and set valid, regardless of out_ack[i]. Ack plus refill keeps valid=1 with the new data.
  - Else if out_valid[i] && out_ack[i]: out_valid[i] <= 0; Saida_i keeps its old value (no clear).
  - Else: hold.
  - out_ack[i] while out_valid[i]=0 is ignored.
- Data stability: Saida_i must not change while out_valid[i]=1 and no ack/refill has occurred.
- Acks to different slots in the same cycle are independent; all four may clear at once.
- in_valid=1 with in_ready=0: nothing changes. The producer may change SEL/Entrada freely; in_ready re-evaluates for the new SEL.
- At most one slot is written per cycle; no internal queue beyond one word per slot.

Optional Feature:
- Macro DESROTEAMENTO_ROUND_ROBIN_EN.
- Defined:
  - SEL is ignored; t comes from an internal 2-bit pointer.
  - Pointer resets to 0 and increments mod 4 (3 wraps to 0) on each accepted word only.
  - A stalled pointer waits on its full slot; there is no skipping.
- Undefined: t = SEL; no pointer logic is synthesised. Port list is identical in both builds.

Test Plan:
- Reset then idle: after reset=1 for 2 cycles → out_valid=0000, all Saida=0, in_ready=1 for every SEL.
- Route all four: SEL=00..11 with Entrada=4'h3,4'h5,4'hA,4'hF on consecutive cycles, no acks → out_valid=1111; Saida_A..D=3,5,A,F; each appears 1 cycle after its accept.
- Backpressure and same-cycle refill:
  - Slot B full with 4'h5, SEL=01, in_valid=1, out_ack=0000 → in_ready=0, Saida_B stays 5.
  - Then out_ack[1]=1 with Entrada=4'h9 → in_ready=1; next cycle Saida_B=9, out_valid[1]=1.
- Ack clears without data change: out_ack=0101 with slots A/C full → next cycle out_valid=1010, Saida_A/C unchanged. Ack on an empty slot → no effect.
- Reset mid-operation: out_valid=1111 and in_valid=1 with reset=1 → next cycle out_valid=0000, all Saida=0, word not loaded.
- Round robin (DESROTEAMENTO_ROUND_ROBIN_EN defined):
  - Five accepts with SEL fixed at 11, acking each slot → words land in A,B,C,D,A.
  - With slot A full and unacked → in_ready=0 on the 5th word.
